// File: rtl/alu_exec_stage.sv
// alu_exec_stage: MIPS execute stage. Logic ops, LUI, MULT/MULTU and MFHI/MFLO
// finish in one cycle; DIV/DIVU use an iterative radix-2 restoring divider
// that holds the front of the pipeline through stall_o. The stage owns HI/LO.
//
// Divider FSM
//   state  | meaning
//   S_IDLE | no divide in flight; a live DIV/DIVU latches operands here
//   S_RUN  | one shift-subtract step per cycle, count 0..DATA_W-1
//   S_DONE | sign fix-up applied, HI/LO written at the end of this cycle
module alu_exec_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic [4:0]        alu_control_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              valid_o,
  output logic              stall_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam logic [4:0] AND_CONTROL   = 5'b00000;
  localparam logic [4:0] OR_CONTROL    = 5'b00001;
  localparam logic [4:0] XOR_CONTROL   = 5'b00010;
  localparam logic [4:0] NOR_CONTROL   = 5'b00011;
  localparam logic [4:0] LUI_CONTROL   = 5'b00100;
  localparam logic [4:0] MULT_CONTROL  = 5'b10000;
  localparam logic [4:0] MULTU_CONTROL = 5'b10001;
  localparam logic [4:0] DIV_CONTROL   = 5'b10010;
  localparam logic [4:0] DIVU_CONTROL  = 5'b10011;
  localparam logic [4:0] MFHI_CONTROL  = 5'b10100;
  localparam logic [4:0] MFLO_CONTROL  = 5'b10101;

  localparam int CNT_W = $clog2(DATA_W);
  localparam int HALF  = DATA_W / 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_t;

  div_state_t        state, state_nxt;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] div_q, div_r, div_d, div_a;
  logic              div_q_neg, div_r_neg, div_by_zero;

  logic              live, is_div, is_sdiv, is_smul;
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   rem_shift;
  logic              rem_ge;
  logic [DATA_W-1:0] rem_next, quo_fix, rem_fix;
  logic [2*DATA_W-1:0] mul_a, mul_b, prod;

  logic [DATA_W-1:0] res_nxt, hi_nxt, lo_nxt;
  logic              val_nxt, hilo_we;

  assign live    = en_i & ~flush_i;
  assign is_div  = (alu_control_i == DIV_CONTROL) | (alu_control_i == DIVU_CONTROL);
  assign is_sdiv = (alu_control_i == DIV_CONTROL);
  assign is_smul = (alu_control_i == MULT_CONTROL);

  // The divide owns EX until DONE; reset overrides so nothing upstream freezes.
  assign stall_o = ~rst & live & is_div & (state != S_DONE);

  // Signed divide works on magnitudes; signs are re-applied in DONE.
  assign a_neg = is_sdiv & src_a_i[DATA_W-1];
  assign b_neg = is_sdiv & src_b_i[DATA_W-1];
  assign a_mag = a_neg ? -src_a_i : src_a_i;
  assign b_mag = b_neg ? -src_b_i : src_b_i;

  // Restoring step: the dividend shifts out of div_q while quotient bits shift in.
  assign rem_shift = {div_r, div_q[DATA_W-1]};
  assign rem_ge    = rem_shift >= {1'b0, div_d};
  assign rem_next  = rem_ge ? (rem_shift[DATA_W-1:0] - div_d) : rem_shift[DATA_W-1:0];

  // Divide-by-zero reports the raw dividend, not its magnitude.
  assign quo_fix = div_by_zero ? '1    : (div_q_neg ? -div_q : div_q);
  assign rem_fix = div_by_zero ? div_a : (div_r_neg ? -div_r : div_r);

  // One multiplier serves both forms; sign- or zero-extend to the product width.
  assign mul_a = {{DATA_W{is_smul & src_a_i[DATA_W-1]}}, src_a_i};
  assign mul_b = {{DATA_W{is_smul & src_b_i[DATA_W-1]}}, src_b_i};
  assign prod  = mul_a * mul_b;

  // Divider state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Divider next-state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (live && is_div) state_nxt = S_RUN;
      S_RUN: begin
        if (flush_i)                         state_nxt = S_IDLE;
        else if (count == CNT_W'(DATA_W-1))  state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Divider datapath: latch operands on issue, iterate while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      div_q       <= '0;
      div_r       <= '0;
      div_d       <= '0;
      div_a       <= '0;
      div_q_neg   <= 1'b0;
      div_r_neg   <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (state == S_IDLE && live && is_div) begin
      count       <= '0;
      div_q       <= a_mag;
      div_r       <= '0;
      div_d       <= b_mag;
      div_a       <= src_a_i;
      div_q_neg   <= a_neg ^ b_neg;
      div_r_neg   <= a_neg;
      div_by_zero <= (src_b_i == '0);
    end else if (state == S_RUN) begin
      count <= count + CNT_W'(1);
      div_q <= {div_q[DATA_W-2:0], rem_ge};
      div_r <= rem_next;
    end
  end

  // Result, valid and HI/LO update selection for the instruction in EX.
  always_comb begin
    res_nxt = '0;
    val_nxt = 1'b0;
    hilo_we = 1'b0;
    hi_nxt  = hi_o;
    lo_nxt  = lo_o;
    if (live) begin
      val_nxt = 1'b1;
      case (alu_control_i)
        AND_CONTROL:  res_nxt = src_a_i & src_b_i;
        OR_CONTROL:   res_nxt = src_a_i | src_b_i;
        XOR_CONTROL:  res_nxt = src_a_i ^ src_b_i;
        NOR_CONTROL:  res_nxt = ~(src_a_i | src_b_i);
        LUI_CONTROL:  res_nxt = {src_b_i[HALF-1:0], {HALF{1'b0}}};
        MFHI_CONTROL: res_nxt = hi_o;
        MFLO_CONTROL: res_nxt = lo_o;
        MULT_CONTROL, MULTU_CONTROL: begin
          hilo_we = 1'b1;
          hi_nxt  = prod[2*DATA_W-1:DATA_W];
          lo_nxt  = prod[DATA_W-1:0];
        end
        DIV_CONTROL, DIVU_CONTROL: begin
          if (state == S_DONE) begin
            hilo_we = 1'b1;
            hi_nxt  = rem_fix;
            lo_nxt  = quo_fix;
          end else begin
            val_nxt = 1'b0;
          end
        end
        default: res_nxt = '0;
      endcase
    end
  end

  // EX/MEM result register and HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_o <= '0;
      valid_o  <= 1'b0;
      hi_o     <= '0;
      lo_o     <= '0;
    end else begin
      result_o <= res_nxt;
      valid_o  <= val_nxt;
      if (hilo_we) begin
        hi_o <= hi_nxt;
        lo_o <= lo_nxt;
      end
    end
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute stage of the MIPS pipeline: consumes the 5-bit ALU control code from the ALU decoder plus the two operands, and produces the registered EX/MEM result. Logic ops and LUI complete in one cycle. MULT/MULTU write HI/LO in one cycle. DIV/DIVU run on an iterative 32-step radix-2 divider that stalls the front of the pipeline. The block owns the HI/LO registers and serves MFHI/MFLO.

## Interface
- DATA_W, 32, operand/result width; HI/LO are DATA_W each.
- clk  in  1  pipeline clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- en_i  in  1  an instruction is present in EX this cycle.
- flush_i  in  1  kill the EX instruction (branch/exception); wins over en_i.
- alu_control_i  in  5  op code using the `*_CONTROL` macros in defines2.vh: AND, OR, XOR, NOR, LUI (existing), plus MULT, MULTU, DIV, DIVU, MFHI, MFLO (added to defines2.vh by this block).
- src_a_i  in  DATA_W  rs operand; held stable by upstream while stall_o=1.
- src_b_i  in  DATA_W  rt operand or zero-extended immediate.
- result_o  out  DATA_W  registered EX/MEM result.
- valid_o  out  1  registered; result_o is from a completed, unflushed instruction.
- stall_o  out  1  combinational; freeze IF/ID/EX while asserted.
- hi_o, lo_o  out  DATA_W  current HI/LO register contents (debug/forward).

## Operation
- AND/OR/XOR/NOR: bitwise on src_a_i, src_b_i.
- LUI: result = {src_b_i[15:0], 16'h0}.
- MFHI/MFLO: result = HI/LO register value at the start of the cycle.
- MULT (signed) / MULTU: 64-bit product, HI=prod[63:32], LO=prod[31:0], result=0.
- DIV (signed) / DIVU: LO=quotient, HI=remainder, result=0.
  - Signed: divide magnitudes, then negate the quotient if the operand signs differ, and give the remainder the sign of the dividend.
  - Divide by zero: LO=32'hFFFF_FFFF, HI=dividend (src_a_i). Applies to both DIV and DIVU.
  - DIV of 32'h8000_0000 by -1: LO=32'h8000_0000, HI=0.
- Unknown code with en_i=1: result=0, valid_o=1, HI/LO unchanged.
- Divider FSM states:
  - IDLE: en_i & !flush_i & op∈{DIV,DIVU} -> RUN. Latch the operand magnitudes and sign flags; count=0.
  - RUN: one shift-subtract step per cycle, count increments. count==31 -> DONE.
  - DONE: apply sign fix-up, write HI/LO at the end of the cycle, assert valid_o next cycle, -> IDLE.
  - flush_i in RUN or DONE -> IDLE. No HI/LO write, no valid_o.
- stall_o = en_i & !flush_i & op∈{DIV,DIVU} & state!=DONE. It is high in the issue cycle, through all of RUN, and low in DONE.

## Timing
- Reset: result_o=0, valid_o=0, HI=0, LO=0, state=IDLE, count=0, stall_o=0 (en_i ignored during rst).
- Single-cycle ops: inputs at edge N, result_o/valid_o visible after edge N+1. HI/LO (MULT*) also update at edge N+1.
- DIV/DIVU:
  - Issue cycle C0 (IDLE, stall_o=1).
  - RUN occupies C1..C32.
  - DONE is C33 (stall_o=0).
  - HI/LO and valid_o update at the edge ending C33.
  - Total: 34 cycles in EX, 33 stalled.
- Back-to-back: MFHI/MFLO in the cycle after DONE, or after a MULT, reads the new value (register written at the preceding edge). No bypass is needed inside the block.
- valid_o=0 in any cycle following a cycle where !en_i, flush_i, or the divider was not in DONE for a DIV op.
- rst mid-divide: FSM to IDLE in one cycle. HI/LO cleared, no completion.
- flush_i during stall: stall_o drops the same cycle (combinational). The divider returns to IDLE at the next edge.
- Upstream must not change alu_control_i/src_*_i while stall_o=1. Behaviour on violation is undefined.

## Test plan
- Reset then logic ops: OR 0x0F0F_0000 | 0x0000_00FF -> result_o=0x0F0F_00FF, valid_o=1 one cycle later. NOR 0,0 -> 0xFFFF_FFFF. LUI imm 0x1234 -> 0x1234_0000.
- MULT -2 × 3 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFFA. MULTU with the same bits -> HI=0x0000_0002, LO=0xFFFF_FFFA. Following MFLO returns 0xFFFF_FFFA.
- DIVU 100/7:
  - stall_o high for exactly 33 cycles.
  - Then LO=14, HI=2, valid_o pulses once.
  - MFHI next cycle -> 2.
- DIV -7/2 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1). DIV 7/0 -> LO=0xFFFF_FFFF, HI=7. DIV 0x8000_0000/-1 -> LO=0x8000_0000, HI=0.
- flush_i asserted in RUN cycle 10 -> stall_o low that cycle, no valid_o, HI/LO keep the prior values. A new DIVU issued the next cycle completes correctly.
- rst asserted in RUN cycle 20 -> next cycle all outputs at reset values, state IDLE, stall_o=0.
